main_ram_wb_adapter: RTL and testbench
======================================

MAIN_RAM_WB_ADAPTER -- requirements
Module: main_ram_wb_adapter

Interface
REQ-001 SHALL have parameter RAM_SIZE_BYTES, default 131072, RAM capacity in bytes (power of two, 4..2^30).
REQ-002 SHALL have parameter RAM_ADDR_W, default 15, RAM word-address width, equal to log2(RAM_SIZE_BYTES/4).
REQ-003 SHALL have port clk  in  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports wb_cyc, wb_stb, wb_we  in  1 each  pipelined Wishbone B4 cycle, strobe, write-enable.
REQ-006 SHALL have port wb_adr  in  28  word address.
REQ-007 SHALL have ports wb_dat_w  in  32 (write data) and wb_sel  in  4 (byte lane selects).
REQ-008 SHALL have ports wb_dat_r  out  32, wb_ack  out  1, wb_err  out  1, wb_stall  out  1.
REQ-009 SHALL have ports bus_addr  out  RAM_ADDR_W, bus_wrdata  out  32, bus_wrbytesel  out  4, bus_write  out  1 (RAM request side).
REQ-010 SHALL have port bus_rddata  in  32; RAM read data is valid one clk after the address edge; write-first semantics.

Function
REQ-011 Request accepted in cycle N iff wb_cyc & wb_stb & !wb_stall.
REQ-012 bus_addr = wb_adr[RAM_ADDR_W-1:0], bus_wrdata = wb_dat_w, bus_wrbytesel = wb_sel, all combinational pass-through.
REQ-013 In-range: wb_adr < RAM_SIZE_BYTES/4 (full 28-bit compare, no aliasing).
REQ-014 bus_write = accepted & wb_we & in-range; out-of-range writes SHALL NOT reach RAM.
REQ-015 Response latency L = 1 (L = 2 under REQ-026); each accepted request yields exactly one response L cycles later, in order.
REQ-016 Response = wb_ack for in-range, wb_err for out-of-range; never both in one cycle.
REQ-017 Response pipeline: L-deep shift register of {valid, is_err}; one request per cycle, back-to-back, no bubbles.
REQ-018 wb_stall = rst; otherwise 0 (full throughput, no backpressure).
REQ-019 wb_ack and wb_err SHALL be gated with wb_cyc; on any cycle wb_cyc = 0, all pipeline valid bits clear on next edge (abort squashes pending responses).
REQ-020 wb_dat_r = RAM read data for read acks; 0 in every cycle without a read ack (including write acks and errors).
REQ-021 Write ack returns no data; read-after-write to same address on consecutive cycles SHALL return the new data.
REQ-022 wb_stb without wb_cyc is ignored: no RAM write, no response.

Reset
REQ-023 While rst = 1: bus_write = 0, wb_ack = 0, wb_err = 0, wb_dat_r = 0, wb_stall = 1, pipeline cleared.
REQ-024 Reset mid-transaction SHALL discard all pending responses; none SHALL appear after rst deasserts.
REQ-025 First request SHALL be accepted in the first cycle with rst = 0.

Configuration
REQ-026 Macro MAIN_RAM_WB_REG_RDDATA_EN defined: bus_rddata registered once before wb_dat_r, L = 2 for all responses (reads, writes, errors); register reset to 0.
REQ-027 Macro undefined: wb_dat_r driven from bus_rddata through the REQ-020 gate only, L = 1.

Verification
REQ-028 Write 0xDEADBEEF, sel 0xF to adr 0x10, then read 0x10 -> ack at N+L each, read data 0xDEADBEEF, no err.
REQ-029 Write 0x000000AA sel 0x1 over 0x11223344 at adr 0x20, read -> 0x112233AA.
REQ-030 Four back-to-back reads adr 0..3 preloaded 0xA0..0xA3 -> four consecutive acks, data 0xA0,0xA1,0xA2,0xA3, wb_stall 0 throughout.
REQ-031 Write to adr 0x8000 (default size) -> wb_err at N+L, no ack, bus_write 0, RAM word 0x0000 unchanged.
REQ-032 Read issued, wb_cyc dropped next cycle (L = 2 build) or rst pulsed -> no ack/err ever emitted for that read.
REQ-033 Write then read same address on consecutive cycles -> read returns the written value.

Source files
------------

// File: rtl/main_ram_wb_adapter.sv
// Pipelined Wishbone B4 slave in front of a single-cycle synchronous main RAM.
// Optional macro MAIN_RAM_WB_REG_RDDATA_EN registers read data (latency 2 instead of 1).
module main_ram_wb_adapter #(
  parameter int RAM_SIZE_BYTES = 131072,
  parameter int RAM_ADDR_W     = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_cyc,
  input  logic                  wb_stb,
  input  logic                  wb_we,
  input  logic [27:0]           wb_adr,
  input  logic [31:0]           wb_dat_w,
  input  logic [3:0]            wb_sel,
  output logic [31:0]           wb_dat_r,
  output logic                  wb_ack,
  output logic                  wb_err,
  output logic                  wb_stall,
  output logic [RAM_ADDR_W-1:0] bus_addr,
  output logic [31:0]           bus_wrdata,
  output logic [3:0]            bus_wrbytesel,
  output logic                  bus_write,
  input  logic [31:0]           bus_rddata
);

`ifdef MAIN_RAM_WB_REG_RDDATA_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  // One extra bit so a 1 GiB RAM (2^28 words) still compares correctly.
  localparam logic [28:0] WORD_LIMIT = 29'(RAM_SIZE_BYTES / 4);

  logic           accept;
  logic           in_range;
  logic           resp_live;
  logic           read_ack;
  logic [LAT-1:0] vld_q, vld_d;
  logic [LAT-1:0] err_q, err_d;
  logic [LAT-1:0] rd_q, rd_d;

  assign wb_stall      = rst;
  assign accept        = wb_cyc & wb_stb & ~wb_stall;
  assign in_range      = ({1'b0, wb_adr} < WORD_LIMIT);

  assign bus_addr      = wb_adr[RAM_ADDR_W-1:0];
  assign bus_wrdata    = wb_dat_w;
  assign bus_wrbytesel = wb_sel;
  assign bus_write     = accept & wb_we & in_range;

  // Response shift register; index LAT-1 is the response presented this cycle.
  // Dropping wb_cyc squashes everything in flight.
  always_comb begin
    vld_d = '0;
    err_d = '0;
    rd_d  = '0;
    if (wb_cyc) begin
      vld_d = LAT'({vld_q, accept});
      err_d = LAT'({err_q, ~in_range});
      rd_d  = LAT'({rd_q, ~wb_we & in_range});
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      err_q <= '0;
      rd_q  <= '0;
    end else begin
      vld_q <= vld_d;
      err_q <= err_d;
      rd_q  <= rd_d;
    end
  end

  assign resp_live = ~rst & wb_cyc & vld_q[LAT-1];
  assign wb_ack    = resp_live & ~err_q[LAT-1];
  assign wb_err    = resp_live & err_q[LAT-1];
  assign read_ack  = wb_ack & rd_q[LAT-1];

`ifdef MAIN_RAM_WB_REG_RDDATA_EN
  logic [31:0] rddata_q, rddata_d;

  always_comb begin
    rddata_d = bus_rddata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rddata_q <= '0;
    end else begin
      rddata_q <= rddata_d;
    end
  end

  assign wb_dat_r = read_ack ? rddata_q : '0;
`else
  assign wb_dat_r = read_ack ? bus_rddata : '0;
`endif

endmodule

// File: tb/tb_main_ram_wb_adapter.sv
// Directed table-driven bench for main_ram_wb_adapter with a byte-lane write-first RAM model.
module tb_main_ram_wb_adapter;

`ifdef MAIN_RAM_WB_REG_RDDATA_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_cyc, wb_stb, wb_we;
  logic [27:0] wb_adr;
  logic [31:0] wb_dat_w;
  logic [3:0]  wb_sel;
  logic [31:0] wb_dat_r;
  logic        wb_ack, wb_err, wb_stall;
  logic [14:0] bus_addr;
  logic [31:0] bus_wrdata;
  logic [3:0]  bus_wrbytesel;
  logic        bus_write;
  logic [31:0] bus_rddata;

  always #5 clk = ~clk;

  main_ram_wb_adapter #(
    .RAM_SIZE_BYTES(131072),
    .RAM_ADDR_W    (15)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wb_cyc       (wb_cyc),
    .wb_stb       (wb_stb),
    .wb_we        (wb_we),
    .wb_adr       (wb_adr),
    .wb_dat_w     (wb_dat_w),
    .wb_sel       (wb_sel),
    .wb_dat_r     (wb_dat_r),
    .wb_ack       (wb_ack),
    .wb_err       (wb_err),
    .wb_stall     (wb_stall),
    .bus_addr     (bus_addr),
    .bus_wrdata   (bus_wrdata),
    .bus_wrbytesel(bus_wrbytesel),
    .bus_write    (bus_write),
    .bus_rddata   (bus_rddata)
  );

  // Write-first RAM: read data one clock after the address edge.
  logic [31:0] mem [0:32767];
  always @(posedge clk) begin
    logic [31:0] w;
    w = mem[bus_addr];
    if (bus_write) begin
      for (int b = 0; b < 4; b++)
        if (bus_wrbytesel[b]) w[8*b +: 8] = bus_wrdata[8*b +: 8];
      mem[bus_addr] <= w;
    end
    bus_rddata <= w;
  end

  typedef struct {
    string       name;
    bit          cyc;
    bit          stb;
    bit          we;
    logic [27:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    bit          exp_bw;
    bit          exp_err;
    logic [31:0] exp_dat;
  } vec_t;

  int checks = 0;
  int failures = 0;

  bit          pend_v [LAT];
  bit          pend_e [LAT];
  logic [31:0] pend_d [LAT];

  function automatic vec_t mk(input string n, input bit c, input bit s, input bit w,
                              input logic [27:0] a, input logic [31:0] d, input logic [3:0] sl,
                              input bit bw, input bit e, input logic [31:0] ed);
    vec_t v;
    v.name = n; v.cyc = c; v.stb = s; v.we = w; v.adr = a; v.dat = d; v.sel = sl;
    v.exp_bw = bw; v.exp_err = e; v.exp_dat = ed;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h required=%08h", nm, act, exp);
    end
  endtask

  // One bus cycle: drive, check this cycle's outputs against the scoreboard, advance it.
  task automatic step(input bit r, input vec_t v);
    bit live;
    @(negedge clk);
    rst = r; wb_cyc = v.cyc; wb_stb = v.stb; wb_we = v.we;
    wb_adr = v.adr; wb_dat_w = v.dat; wb_sel = v.sel;
    #1;
    live = !r && v.cyc && pend_v[LAT-1];
    chk({v.name, ":stall"}, 32'(wb_stall), 32'(r));
    chk({v.name, ":bus_write"}, 32'(bus_write), r ? 32'd0 : 32'(v.exp_bw));
    chk({v.name, ":bus_addr"}, 32'(bus_addr), 32'(v.adr[14:0]));
    chk({v.name, ":ack"}, 32'(wb_ack), 32'(live && !pend_e[LAT-1]));
    chk({v.name, ":err"}, 32'(wb_err), 32'(live && pend_e[LAT-1]));
    chk({v.name, ":dat_r"}, wb_dat_r, (live && !pend_e[LAT-1]) ? pend_d[LAT-1] : 32'd0);
    $display("cyc %s rst=%0b adr=%07h we=%0b bw=%0b ack=%0b err=%0b dat_r=%08h",
             v.name, r, v.adr, v.we, bus_write, wb_ack, wb_err, wb_dat_r);
    if (r || !v.cyc) begin
      for (int i = 0; i < LAT; i++) begin
        pend_v[i] = 1'b0; pend_e[i] = 1'b0; pend_d[i] = '0;
      end
    end else begin
      for (int i = LAT - 1; i > 0; i--) begin
        pend_v[i] = pend_v[i-1]; pend_e[i] = pend_e[i-1]; pend_d[i] = pend_d[i-1];
      end
      pend_v[0] = v.stb;
      pend_e[0] = v.exp_err;
      pend_d[0] = v.exp_dat;
    end
  endtask

  vec_t vecs [23];
  vec_t idle;

  initial begin
    for (int i = 0; i < LAT; i++) begin
      pend_v[i] = 1'b0; pend_e[i] = 1'b0; pend_d[i] = '0;
    end
    rst = 1'b1; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    wb_adr = '0; wb_dat_w = '0; wb_sel = '0;
    idle = mk("idle", 1, 0, 0, 28'h0, 32'h0, 4'h0, 0, 0, 32'h0);

    //                name       cyc stb we adr          dat           sel   bw err exp_dat
    vecs[0]  = mk("wr10",      1, 1, 1, 28'h10,      32'hDEADBEEF, 4'hF, 1, 0, 32'h0);
    vecs[1]  = mk("rd10",      1, 1, 0, 28'h10,      32'h0,        4'hF, 0, 0, 32'hDEADBEEF);
    vecs[2]  = mk("wr20",      1, 1, 1, 28'h20,      32'h11223344, 4'hF, 1, 0, 32'h0);
    vecs[3]  = mk("wr20b0",    1, 1, 1, 28'h20,      32'h000000AA, 4'h1, 1, 0, 32'h0);
    vecs[4]  = mk("rd20",      1, 1, 0, 28'h20,      32'h0,        4'hF, 0, 0, 32'h112233AA);
    vecs[5]  = mk("wr0",       1, 1, 1, 28'h0,       32'h000000A0, 4'hF, 1, 0, 32'h0);
    vecs[6]  = mk("wr1",       1, 1, 1, 28'h1,       32'h000000A1, 4'hF, 1, 0, 32'h0);
    vecs[7]  = mk("wr2",       1, 1, 1, 28'h2,       32'h000000A2, 4'hF, 1, 0, 32'h0);
    vecs[8]  = mk("wr3",       1, 1, 1, 28'h3,       32'h000000A3, 4'hF, 1, 0, 32'h0);
    vecs[9]  = mk("rd0",       1, 1, 0, 28'h0,       32'h0,        4'hF, 0, 0, 32'h000000A0);
    vecs[10] = mk("rd1",       1, 1, 0, 28'h1,       32'h0,        4'hF, 0, 0, 32'h000000A1);
    vecs[11] = mk("rd2",       1, 1, 0, 28'h2,       32'h0,        4'hF, 0, 0, 32'h000000A2);
    vecs[12] = mk("rd3",       1, 1, 0, 28'h3,       32'h0,        4'hF, 0, 0, 32'h000000A3);
    vecs[13] = mk("wr8000",    1, 1, 1, 28'h8000,    32'hFFFFFFFF, 4'hF, 0, 1, 32'h0);
    vecs[14] = mk("rd0chk",    1, 1, 0, 28'h0,       32'h0,        4'hF, 0, 0, 32'h000000A0);
    vecs[15] = mk("rdFFFFFFF", 1, 1, 0, 28'hFFFFFFF, 32'h0,        4'hF, 0, 1, 32'h0);
    vecs[16] = mk("wr7FFF",    1, 1, 1, 28'h7FFF,    32'h55AA55AA, 4'hF, 1, 0, 32'h0);
    vecs[17] = mk("rd7FFF",    1, 1, 0, 28'h7FFF,    32'h0,        4'hF, 0, 0, 32'h55AA55AA);
    vecs[18] = mk("idle18",    1, 0, 0, 28'h0,       32'h0,        4'h0, 0, 0, 32'h0);
    vecs[19] = mk("stbnocyc",  0, 1, 1, 28'h10,      32'h0,        4'hF, 0, 0, 32'h0);
    vecs[20] = mk("idle20",    1, 0, 0, 28'h0,       32'h0,        4'h0, 0, 0, 32'h0);
    vecs[21] = mk("rd10again", 1, 1, 0, 28'h10,      32'h0,        4'hF, 0, 0, 32'hDEADBEEF);
    vecs[22] = mk("idle22",    1, 0, 0, 28'h0,       32'h0,        4'h0, 0, 0, 32'h0);

    // Request driven while in reset must neither write nor respond.
    step(1'b1, mk("rstwr", 1, 1, 1, 28'h40, 32'h12345678, 4'hF, 0, 0, 32'h0));
    step(1'b1, mk("rstwr", 1, 1, 1, 28'h40, 32'h12345678, 4'hF, 0, 0, 32'h0));

    // Row 0 lands in the first cycle with rst low.
    for (int i = 0; i < 23; i++) step(1'b0, vecs[i]);
    for (int i = 0; i < LAT + 1; i++) step(1'b0, idle);

    // Abort: read, then drop wb_cyc; its response must never show up.
    step(1'b0, mk("ab_rd", 1, 1, 0, 28'h10, 32'h0, 4'hF, 0, 0, 32'hDEADBEEF));
    step(1'b0, mk("ab_drop", 0, 0, 0, 28'h0, 32'h0, 4'h0, 0, 0, 32'h0));
    for (int i = 0; i < LAT + 1; i++) step(1'b0, idle);

    // Reset pulse mid-transaction discards the pending read.
    step(1'b0, mk("rs_rd", 1, 1, 0, 28'h20, 32'h0, 4'hF, 0, 0, 32'h112233AA));
    step(1'b1, idle);
    for (int i = 0; i < LAT + 1; i++) step(1'b0, idle);

    // Recovery: a normal read after both disruptions.
    step(1'b0, mk("rec_rd", 1, 1, 0, 28'h10, 32'h0, 4'hF, 0, 0, 32'hDEADBEEF));
    for (int i = 0; i < LAT + 1; i++) step(1'b0, idle);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
